// File: rtl/sample_capture_pkg.sv
// Shared types and default sizes for the sample_capture block.
package sample_capture_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READOUT = 2'd3
  } state_e;

endpackage

// File: rtl/sc_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port with read enable.
module sc_ram
  import sample_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // NOTE: neither the array nor the read register is reset, so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sample_capture.sv
// Arm / optional skip / capture 2**ADDR_W samples / stream them out with valid-ready.
// Define SAMPLE_CAPTURE_PEAK_EN to add running signed peak_max/peak_min outputs.
module sample_capture
  import sample_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SKIP_N = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] d,
  input  logic              sample_en,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last
`ifdef SAMPLE_CAPTURE_PEAK_EN
  ,
  output logic signed [DATA_W-1:0] peak_max,
  output logic signed [DATA_W-1:0] peak_min
`endif
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int SKIP_W = (SKIP_N > 1) ? $clog2(SKIP_N) : 1;
  localparam logic [ADDR_W:0]   RA_END    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   RA_LAST   = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] WA_LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_N > 0) ? SKIP_N - 1 : 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [ADDR_W:0]   ra_q, ra_d;
  logic              ram_vld_q, ram_vld_d;
  logic              ram_last_q, ram_last_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              done_q, done_d;
  logic              we, re, out_ld;
  logic [DATA_W-1:0] ram_rdata;

  sc_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wa_q),
    .wdata (d),
    .re    (re),
    .raddr (ra_q[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state_q;
    wa_d       = wa_q;
    skip_d     = skip_q;
    ra_d       = ra_q;
    ram_vld_d  = ram_vld_q;
    ram_last_d = ram_last_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    done_d     = 1'b0;
    we         = 1'b0;
    re         = 1'b0;
    out_ld     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          wa_d    = '0;
          skip_d  = '0;
          ra_d    = '0;
          state_d = (SKIP_N == 0) ? ST_CAPTURE : ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (sample_en) begin
          if (skip_q == SKIP_LAST) state_d = ST_CAPTURE;
          else                     skip_d  = skip_q + SKIP_W'(1);
        end
      end
      ST_CAPTURE: begin
        if (sample_en) begin
          we   = 1'b1;
          wa_d = wa_q + ADDR_W'(1);
          if (wa_q == WA_LAST) state_d = ST_READOUT;
        end
      end
      ST_READOUT: begin
        // Two-stage pipe (RAM read register, output register); a stage refills only when it drains.
        out_ld = ram_vld_q && (!rd_valid_q || rd_ready);
        re     = (ra_q != RA_END) && (!ram_vld_q || out_ld);
        if (re) begin
          ra_d       = ra_q + (ADDR_W+1)'(1);
          ram_last_d = (ra_q == RA_LAST);
        end
        ram_vld_d = re || (ram_vld_q && !out_ld);
        if (out_ld) begin
          rd_data_d  = ram_rdata;
          rd_last_d  = ram_last_q;
          rd_valid_d = 1'b1;
        end else if (rd_valid_q && rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end
        if (rd_valid_q && rd_ready && rd_last_q) begin
          done_d    = 1'b1;
          ram_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wa_q       <= '0;
      skip_q     <= '0;
      ra_q       <= '0;
      ram_vld_q  <= 1'b0;
      ram_last_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wa_q       <= wa_d;
      skip_q     <= skip_d;
      ra_q       <= ra_d;
      ram_vld_q  <= ram_vld_d;
      ram_last_q <= ram_last_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;

`ifdef SAMPLE_CAPTURE_PEAK_EN
  localparam logic signed [DATA_W-1:0] S_MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] S_MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  logic signed [DATA_W-1:0] d_s;
  logic signed [DATA_W-1:0] peak_max_q, peak_min_q;

  assign d_s = d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      peak_max_q <= S_MOST_NEG;
      peak_min_q <= S_MOST_POS;
    end else if (state_q == ST_IDLE && start) begin
      peak_max_q <= S_MOST_NEG;
      peak_min_q <= S_MOST_POS;
    end else if (we) begin
      if (d_s > peak_max_q) peak_max_q <= d_s;
      if (d_s < peak_min_q) peak_min_q <= d_s;
    end
  end

  assign peak_max = peak_max_q;
  assign peak_min = peak_min_q;
`endif

endmodule

// File: tb/tb_sample_capture.sv
// Self-checking bench for sample_capture: directed sequence with randomized data against a queue model.
module tb_sample_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instance A: 16 words, no skip.
  logic        a_reset_n, a_sample_en, a_start, a_busy, a_done, a_rd_valid, a_rd_ready, a_rd_last;
  logic [15:0] a_d, a_rd_data;
  // Instance B: 16 words, skip 3.
  logic        g_reset_n, b_sample_en, b_start, b_busy, b_done, b_rd_valid, b_rd_ready, b_rd_last;
  logic [15:0] b_d, b_rd_data;
`ifdef SAMPLE_CAPTURE_PEAK_EN
  logic [15:0] a_pmax, a_pmin, b_pmax, b_pmin, c_pmax, c_pmin;
  logic        c_sample_en, c_start, c_busy, c_done, c_rd_valid, c_rd_ready, c_rd_last;
  logic [15:0] c_d, c_rd_data;
`endif

  sample_capture #(.DATA_W(16), .ADDR_W(4), .SKIP_N(0)) dut_a (
    .clk(clk), .reset_n(a_reset_n), .d(a_d), .sample_en(a_sample_en), .start(a_start),
    .busy(a_busy), .done(a_done), .rd_valid(a_rd_valid), .rd_ready(a_rd_ready),
    .rd_data(a_rd_data), .rd_last(a_rd_last)
`ifdef SAMPLE_CAPTURE_PEAK_EN
    , .peak_max(a_pmax), .peak_min(a_pmin)
`endif
  );

  sample_capture #(.DATA_W(16), .ADDR_W(4), .SKIP_N(3)) dut_b (
    .clk(clk), .reset_n(g_reset_n), .d(b_d), .sample_en(b_sample_en), .start(b_start),
    .busy(b_busy), .done(b_done), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
    .rd_data(b_rd_data), .rd_last(b_rd_last)
`ifdef SAMPLE_CAPTURE_PEAK_EN
    , .peak_max(b_pmax), .peak_min(b_pmin)
`endif
  );

`ifdef SAMPLE_CAPTURE_PEAK_EN
  sample_capture #(.DATA_W(16), .ADDR_W(10), .SKIP_N(0)) dut_c (
    .clk(clk), .reset_n(g_reset_n), .d(c_d), .sample_en(c_sample_en), .start(c_start),
    .busy(c_busy), .done(c_done), .rd_valid(c_rd_valid), .rd_ready(c_rd_ready),
    .rd_data(c_rd_data), .rd_last(c_rd_last), .peak_max(c_pmax), .peak_min(c_pmin)
  );
`endif

  logic [15:0] exp_q[$];

  // Arms A, then feeds samples until the model holds 16 stored words.
  // en_mode: 0 always qualified, 1 alternating 1/0, 2 random. ramp: qualified d counts up from base.
  task automatic a_capture(input int en_mode, input bit ramp, input logic [15:0] base);
    int k = 0;
    logic en;
    logic [15:0] v = base;
    exp_q.delete();
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    check("busy_after_start", a_busy, 1);
    while (exp_q.size() < 16 && k < 200) begin
      case (en_mode)
        0:       en = 1'b1;
        1:       en = (k % 2 == 0);
        default: en = 1'($urandom_range(0, 1));
      endcase
      a_sample_en = en;
      a_d = (en && ramp) ? v : 16'($urandom);
      if (en) begin
        exp_q.push_back(a_d);
        v = v + 16'd1;
      end
      k++;
      if (exp_q.size() < 16) @(negedge clk);
    end
    check("capture_count", exp_q.size(), 16);
  endtask

  // Drains A's readout; checks order, rd_last, optional stall, latency/throughput and the done pulse.
  task automatic a_readout(input int stall_word, input bit rand_ready, input int start_at, input bit timing);
    int got = 0, cyc = 0, first_v = -1, last_hs = -1, done_early = 0, stall_left = 5;
    bit fin = 0, hs_done = 0;
    while (!fin && cyc < 300) begin
      @(negedge clk); cyc++;
      a_sample_en = 1'($urandom_range(0, 1));
      a_d = 16'($urandom);
      a_start = 1'b0;
      if (hs_done) begin
        check("done_pulse", a_done, 1);
        check("busy_after_done", a_busy, 0);
        check("valid_after_done", a_rd_valid, 0);
        fin = 1;
      end else begin
        if (a_rd_valid === 1'b1 && first_v < 0) first_v = cyc;
        if (a_done !== 1'b0) done_early++;
        if (got == stall_word && stall_left > 0) begin
          a_rd_ready = 1'b0;
          stall_left--;
          check("stall_valid", a_rd_valid, 1);
          check("stall_data", a_rd_data, exp_q[0]);
          check("stall_last", a_rd_last, 0);
        end else begin
          a_rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (got == start_at) a_start = 1'b1;
        if (a_rd_valid === 1'b1 && a_rd_ready) begin
          check("rd_data", a_rd_data, exp_q.pop_front());
          check("rd_last", a_rd_last, (got == 15));
          got++;
          if (got == 16) begin
            hs_done = 1;
            last_hs = cyc;
          end
        end
      end
    end
    check("readout_finished", fin, 1);
    check("done_not_early", done_early, 0);
    if (timing) begin
      check("first_valid_latency", first_v, 3);
      check("last_handshake_cycle", last_hs, 18);
    end
    a_start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", a_done, 0);
    check("idle_stays", a_busy, 0);
  endtask

  initial begin
    a_reset_n = 1'b0; a_sample_en = 1'b0; a_start = 1'b0; a_rd_ready = 1'b0; a_d = '0;
    g_reset_n = 1'b0; b_sample_en = 1'b0; b_start = 1'b0; b_rd_ready = 1'b0; b_d = '0;
`ifdef SAMPLE_CAPTURE_PEAK_EN
    c_sample_en = 1'b0; c_start = 1'b0; c_rd_ready = 1'b0; c_d = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_valid", a_rd_valid, 0);
    check("rst_last", a_rd_last, 0);
    check("rst_data", a_rd_data, 0);
    a_reset_n = 1'b1;
    g_reset_n = 1'b1;

    // Ramp 0..15 at full throughput; start pulsed on the final handshake must be ignored.
    a_capture(0, 1'b1, 16'd0);
    a_readout(-1, 1'b0, 15, 1'b1);
    // Alternating sample_en: only qualified samples stored.
    a_capture(1, 1'b0, 16'd0);
    a_readout(-1, 1'b0, -1, 1'b0);
    // Stall five cycles on word 7, with a start pulse mid-readout.
    a_capture(0, 1'b1, 16'd0);
    a_readout(7, 1'b0, 3, 1'b0);

    // Reset one cycle after the 5th capture write.
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_sample_en = 1'b1;
      a_d = 16'(50 + i);
      @(negedge clk);
    end
    a_reset_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", a_busy, 0);
    check("midrst_done", a_done, 0);
    check("midrst_valid", a_rd_valid, 0);
    check("midrst_last", a_rd_last, 0);
    check("midrst_data", a_rd_data, 0);
    a_reset_n = 1'b1;
    a_capture(0, 1'b1, 16'd300);
    a_readout(-1, 1'b0, -1, 1'b0);

    // Random data, random qualification, random backpressure.
    for (int r = 0; r < 2; r++) begin
      a_capture(2, 1'b0, 16'd0);
      a_readout(-1, 1'b1, -1, 1'b0);
    end

    // Instance B: three qualified samples skipped (with an unqualified gap inside the skip window).
    begin
      logic [15:0] bq[$];
      int got = 0, cyc = 0;
      @(negedge clk); b_start = 1'b1;
      @(negedge clk); b_start = 1'b0;
      check("b_busy_after_start", b_busy, 1);
      for (int i = 0; i < 20; i++) begin
        b_sample_en = (i != 1);
        b_d = (i == 1) ? 16'd999 : 16'(100 + i - ((i > 1) ? 1 : 0));
        if (b_sample_en) bq.push_back(b_d);
        @(negedge clk);
      end
      b_sample_en = 1'b0;
      repeat (3) void'(bq.pop_front());
      b_rd_ready = 1'b1;
      while (got < 16 && cyc < 60) begin
        @(negedge clk); cyc++;
        if (b_rd_valid === 1'b1) begin
          check(got == 0 ? "b_first_word" : "b_rd_data", b_rd_data, bq.pop_front());
          got++;
        end
      end
      check("b_word_count", got, 16);
      @(negedge clk);
      check("b_done", b_done, 1);
      check("b_idle", b_busy, 0);
    end

`ifdef SAMPLE_CAPTURE_PEAK_EN
    // 1024-sample sine on the ADDR_W=10 instance; peaks compared with the generated extremes.
    begin
      real amp;
      int ph, v, smax, smin, got, cyc;
      logic [15:0] cq[$];
      amp = 20000.0 + real'($urandom_range(0, 12000));
      ph = int'($urandom_range(0, 1023));
      smax = -40000;
      smin = 40000;
      check("c_rst_max", c_pmax, 16'h8000);
      check("c_rst_min", c_pmin, 16'h7fff);
      @(negedge clk); c_start = 1'b1;
      @(negedge clk); c_start = 1'b0;
      check("c_init_max", c_pmax, 16'h8000);
      check("c_init_min", c_pmin, 16'h7fff);
      for (int i = 0; i < 1024; i++) begin
        v = $rtoi($floor(amp * $sin(6.283185307179586 * real'(i + ph) / 1024.0) + 0.5));
        if (v > smax) smax = v;
        if (v < smin) smin = v;
        c_d = 16'(v);
        c_sample_en = 1'b1;
        cq.push_back(c_d);
        if (i < 1023) @(negedge clk);
      end
      c_rd_ready = 1'b1;
      got = 0;
      cyc = 0;
      while (got < 1024 && cyc < 1100) begin
        @(negedge clk); cyc++;
        c_d = 16'($urandom);
        c_start = (got == 500);
        if (got == 600) begin
          check("c_hold_max", c_pmax, 16'(smax));
          check("c_hold_min", c_pmin, 16'(smin));
        end
        if (c_rd_valid === 1'b1) begin
          check("c_rd_data", c_rd_data, cq.pop_front());
          got++;
        end
      end
      c_start = 1'b0;
      check("c_word_count", got, 1024);
      @(negedge clk);
      check("c_done", c_done, 1);
      check("c_idle", c_busy, 0);
      @(negedge clk);
      check("c_start_ignored", c_busy, 0);
      check("c_peak_max", c_pmax, 16'(smax));
      check("c_peak_min", c_pmin, 16'(smin));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sample_capture.md
SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the sample width in bits (two's complement).
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning capture depth is 2**ADDR_W samples.
REQ-003 The block SHALL have parameter SKIP_N, default 0, meaning qualified samples discarded after start before storing.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port d, input, DATA_W bits: sample stream, typically the filter output q.
REQ-007 The block SHALL have port sample_en, input, 1 bit: qualifies d in the current cycle.
REQ-008 The block SHALL have port start, input, 1 bit: arm request, sampled only in IDLE.
REQ-009 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse after the final readout word.
REQ-011 The block SHALL have port rd_valid, output, 1 bit: rd_data is valid.
REQ-012 The block SHALL have port rd_ready, input, 1 bit: consumer accepts the word.
REQ-013 The block SHALL have port rd_data, output, DATA_W bits: readout word, oldest first.
REQ-014 The block SHALL have port rd_last, output, 1 bit: marks word 2**ADDR_W-1 while rd_valid is high.

Function
REQ-015 The FSM SHALL have states IDLE, SKIP, CAPTURE and READOUT.
REQ-016 On start in IDLE, the FSM SHALL move to SKIP next cycle, or directly to CAPTURE when SKIP_N=0; start outside IDLE SHALL be ignored.
REQ-017 In SKIP, the FSM SHALL count qualified samples and enter CAPTURE on the cycle after the SKIP_N-th one.
REQ-018 In CAPTURE, each cycle with sample_en=1 SHALL write d unmodified to write address wa and increment wa; cycles with sample_en=0 SHALL neither write nor advance.
REQ-019 After the 2**ADDR_W-th write (wa wraps to 0), the FSM SHALL enter READOUT; no further samples SHALL be stored.
REQ-020 In READOUT, rd_valid SHALL rise 2 cycles after state entry (synchronous RAM read plus output register).
REQ-021 While rd_valid=1 and rd_ready=0, rd_data, rd_valid and rd_last SHALL hold stable.
REQ-022 A handshake (rd_valid=1 and rd_ready=1) SHALL present the next word on the following cycle; full throughput is 1 word per cycle.
REQ-023 On the handshake with rd_last=1, the block SHALL drop rd_valid, pulse done for exactly 1 cycle and return to IDLE; start in that same cycle SHALL be ignored.
REQ-024 Readout order SHALL equal capture order (address 0 first).

Reset
REQ-025 Reset (reset_n=0 at a clock edge) SHALL force IDLE and clear all counters, with busy=0, done=0, rd_valid=0, rd_last=0 and rd_data=0.
REQ-026 Reset asserted mid-capture or mid-readout SHALL abort immediately; RAM contents are not cleared.

Configuration
REQ-027 With macro SAMPLE_CAPTURE_PEAK_EN defined, the block SHALL add outputs peak_max and peak_min (each DATA_W bits, signed), holding the running signed max and min of stored samples.
REQ-028 peak_max and peak_min SHALL be initialised on start (and on reset) to the most negative value for max and the most positive value for min; they update in the cycle after each write and hold through READOUT until the next start.
REQ-029 Without SAMPLE_CAPTURE_PEAK_EN, the ports and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package sample_capture_pkg SHALL hold the state enum type and the default DATA_W and ADDR_W constants.
REQ-031 Sub-module sc_ram SHALL implement the simple dual-port RAM (1 write port, 1 registered read port, 2**ADDR_W x DATA_W).

Verification
REQ-032 The bench SHALL run with ADDR_W=4, SKIP_N=0, sample_en=1, d=0..15 and rd_ready=1, and check 16 words 0..15 with rd_last on word 15 and done pulsed once, then busy=0.
REQ-033 The bench SHALL run with SKIP_N=3, d=100,101,... and check that the first word read is 103.
REQ-034 The bench SHALL toggle sample_en 1,0,1,0 during capture and check that only qualified samples are stored, with no gaps or duplicates.
REQ-035 The bench SHALL hold rd_ready=0 for 5 cycles at word 7 and check that rd_data stays 7 and rd_valid stays 1, and that no word is lost.
REQ-036 The bench SHALL assert reset_n=0 for 1 cycle after the 5th capture write and check that all outputs return to their reset values; a new start then captures from address 0.
REQ-037 With SAMPLE_CAPTURE_PEAK_EN, the bench SHALL capture a 1024-sample 16-bit sine with ADDR_W=10 and check peak_max and peak_min against the file's extremes; it SHALL also pulse start during READOUT and check that it is ignored.
